// File: rtl/unpad10_1.sv
// Serial pad10*1 stripper: checks the trailing pad '1' of a padded string, then
// scans downward one bit per cycle for the leading pad '1' to recover the message length.
module unpad10_1 #(
  parameter int P_BITS = 256,
  parameter int L_BITS = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [P_BITS-1:0] p,
  input  logic [L_BITS-1:0] p_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [L_BITS-1:0] m_len
);

  typedef enum logic [1:0] {IDLE, CHECK, SCAN, DONE} state_t;

  localparam logic [L_BITS-1:0] P_MAX = L_BITS'(P_BITS);

  state_t            state_q;
  logic [P_BITS-1:0] p_q;
  logic [L_BITS-1:0] len_q;
  logic [L_BITS-1:0] idx_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [L_BITS-1:0] m_len_q;

  logic [L_BITS-1:0] tail_idx;
  logic              len_bad;
  logic              scan_bit;

  // Shift-based extraction stays in range for any index width and yields 0 off the top.
  function automatic logic bit_at(input logic [P_BITS-1:0] v, input logic [L_BITS-1:0] i);
    return 1'(v >> i);
  endfunction

  assign tail_idx = len_q - L_BITS'(1);
  assign len_bad  = (len_q < L_BITS'(2)) || (len_q > P_MAX) || !bit_at(p_q, tail_idx);
  assign scan_bit = bit_at(p_q, idx_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      m_len_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            p_q     <= p;
            len_q   <= p_len;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            m_len_q <= '0;
            state_q <= CHECK;
          end else begin
            state_q <= IDLE;
          end
        end
        CHECK: begin
          if (len_bad) begin
            err_q   <= 1'b1;
            m_len_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q   <= len_q - L_BITS'(2);
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (scan_bit) begin
            err_q   <= 1'b0;
            m_len_q <= idx_q;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (idx_q == '0) begin
            // Ran off the bottom without finding the leading pad bit.
            err_q   <= 1'b1;
            m_len_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q - L_BITS'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;
  assign m_len = m_len_q;

endmodule

// File: tb/tb_unpad10_1.sv
// Scoreboard bench for unpad10_1: the driver queues expected results from a
// reference model, the monitor pops and checks on every done pulse.
module tb_unpad10_1;
  localparam int P_BITS = 256;
  localparam int L_BITS = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [P_BITS-1:0] p;
  logic [L_BITS-1:0] p_len;
  logic              busy;
  logic              done;
  logic              err;
  logic [L_BITS-1:0] m_len;

  typedef struct {
    logic err;
    int   m;
    int   lat;
    int   due;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int busy_run = 0;

  unpad10_1 #(.P_BITS(P_BITS), .L_BITS(L_BITS)) dut (
    .clk(clk), .rst(rst), .start(start), .p(p), .p_len(p_len),
    .busy(busy), .done(done), .err(err), .m_len(m_len)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference: the string is valid only if length is in range and the top bit is 1;
  // the message ends just below the highest '1' strictly under the top bit.
  function automatic exp_t model(input logic [P_BITS-1:0] v, input int len);
    exp_t e;
    e.err = 1'b1;
    e.m   = 0;
    e.lat = 2;
    e.due = 0;
    if (len >= 2 && len <= P_BITS) begin
      if (v[len-1]) begin
        e.lat = 3 + (len - 2);
        for (int i = len - 2; i >= 0; i--) begin
          if (v[i]) begin
            e.err = 1'b0;
            e.m   = i;
            e.lat = 3 + (len - 2 - i);
            break;
          end
        end
      end
    end
    return e;
  endfunction

  function automatic logic [P_BITS-1:0] rand_vec();
    logic [P_BITS-1:0] v;
    for (int i = 0; i < P_BITS / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic issue(input logic [P_BITS-1:0] v, input int len, input bit expect_res);
    exp_t e;
    p     = v;
    p_len = L_BITS'(len);
    start = 1'b1;
    if (expect_res) begin
      e = model(v, len);
      e.due = cyc + e.lat;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    p     = rand_vec();
    p_len = L_BITS'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: pending=%0d expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL wait_done_timeout: done=%0d expected 1", done);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst) begin
      busy_run = 0;
    end else begin
      if (done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: done=1 expected 0 (cycle %0d)", cyc);
        end else begin
          me = sb.pop_front();
          chk("err", 32'(err), 32'(me.err));
          chk("m_len", 32'(m_len), 32'(me.m));
          chk("done_cycle", cyc, me.due);
          chk("busy_at_done", 32'(busy), 0);
          chk("busy_cycles", busy_run, me.lat - 1);
        end
      end
      busy_run = busy ? busy_run + 1 : 0;
    end
  end

  initial begin
    logic [P_BITS-1:0] v;
    int len;
    rst   = 1'b1;
    start = 1'b0;
    p     = '0;
    p_len = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_m_len", 32'(m_len), 0);
    rst = 1'b0;
    @(negedge clk);

    v = '0; v[7:0] = 8'b1000_0101;
    issue(v, 8, 1'b1); drain();
    v = '0; v[1:0] = 2'b11;
    issue(v, 2, 1'b1); drain();
    v = '1;
    issue(v, 2, 1'b1); drain();
    v = '0; v[6:0] = 7'h7f;
    issue(v, 8, 1'b1); drain();
    v = '1;
    issue(v, 1, 1'b1); drain();
    issue(v, 0, 1'b1); drain();
    issue(v, 257, 1'b1); drain();
    v = '0; v[3:0] = 4'b1000;
    issue(v, 4, 1'b1); drain();
    v = '0; v[255] = 1'b1; v[0] = 1'b1;
    issue(v, 256, 1'b1); drain();

    // start pulses while scanning must not disturb the running operation
    v = '0; v[199] = 1'b1; v[50] = 1'b1;
    issue(v, 200, 1'b1);
    repeat (5) @(negedge clk);
    p = rand_vec(); p_len = 9'd12; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // back-to-back: second start presented in the DONE cycle
    v = '0; v[9] = 1'b1; v[4] = 1'b1;
    issue(v, 10, 1'b1);
    wait_done();
    v = '0; v[5] = 1'b1; v[3] = 1'b1;
    issue(v, 6, 1'b1);
    drain();

    // reset while scanning aborts silently
    v = '0; v[99] = 1'b1; v[0] = 1'b1;
    issue(v, 100, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_m_len", 32'(m_len), 0);
    repeat (120) @(negedge clk);

    for (int k = 0; k < 40; k++) begin
      len = $urandom_range(0, 262);
      v = rand_vec() & rand_vec() & rand_vec();
      if ($urandom_range(0, 3) != 0 && len >= 1 && len <= P_BITS) v[len-1] = 1'b1;
      issue(v, len, 1'b1);
      if ($urandom_range(0, 1) == 1) drain();
      else wait_done();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
